// File: rtl/decoder_seq_onehot.sv
// Binary-to-one-hot decoder with registered outputs and an index counter
// that can follow sel directly, scan up/down to LAST, or single-step.
module decoder_seq_onehot #(
    parameter int N    = 3,
    parameter int LAST = 2**N - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    input  logic              step,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      idx,
    output logic              valid,
    output logic              wrap
);

    localparam int W = 2**N;
    localparam logic [N-1:0] LAST_V = N'(LAST);

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_STEP      = 2'b11
    } mode_e;

    mode_e          mode_s;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   sel_clamp, cnt_inc, cnt_dec;
    logic           up_wrap, dn_wrap;
    logic           wrap_q, wrap_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   y_q, y_d, dec;

    assign mode_s = mode_e'(mode);

    // Counts above LAST (left over from DIRECT) wrap on the next up-advance.
    always_comb begin
        sel_clamp = (sel > LAST_V) ? LAST_V : sel;
        up_wrap   = (cnt_q >= LAST_V);
        cnt_inc   = up_wrap ? '0 : cnt_q + N'(1);
        dn_wrap   = (cnt_q == '0);
        cnt_dec   = dn_wrap ? LAST_V : cnt_q - N'(1);
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (en) begin
            case (mode_s)
                MODE_DIRECT: cnt_d = sel;
                MODE_SCAN_UP: begin
                    if (load) begin
                        cnt_d = sel_clamp;
                    end else begin
                        cnt_d  = cnt_inc;
                        wrap_d = up_wrap;
                    end
                end
                MODE_SCAN_DOWN: begin
                    if (load) begin
                        cnt_d = sel_clamp;
                    end else begin
                        cnt_d  = cnt_dec;
                        wrap_d = dn_wrap;
                    end
                end
                MODE_STEP: begin
                    if (load) begin
                        cnt_d = sel_clamp;
                    end else if (step) begin
                        cnt_d  = cnt_inc;
                        wrap_d = up_wrap;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Decode the next count so y and idx always update together.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign dec[gi] = (cnt_d == N'(gi));
        end
    endgenerate

    always_comb begin
        y_d     = en ? dec : '0;
        valid_d = en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y     = y_q;
    assign idx   = cnt_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Directed bench: vector table on an N=3/LAST=5 instance, plus DIRECT and
// SCAN_UP sweeps on N=2 and N=4 instances with default LAST.
module tb_decoder_seq_onehot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, load, step;
    logic [1:0] mode;
    logic [2:0] sel3;
    logic [1:0] sel2;
    logic [3:0] sel4;

    logic [7:0]  y3;  logic [2:0] idx3; logic valid3, wrap3;
    logic [3:0]  y2;  logic [1:0] idx2; logic valid2, wrap2;
    logic [15:0] y4;  logic [3:0] idx4; logic valid4, wrap4;

    int checks = 0;
    int errors = 0;

    decoder_seq_onehot #(.N(3), .LAST(5)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel3),
        .load(load), .step(step), .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3));

    decoder_seq_onehot #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel2),
        .load(load), .step(step), .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2));

    decoder_seq_onehot #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel4),
        .load(load), .step(step), .y(y4), .idx(idx4), .valid(valid4), .wrap(wrap4));

    typedef struct {
        string      name;
        logic       rst_n, en;
        logic [1:0] mode;
        logic [2:0] sel;
        logic       load, step;
        logic [7:0] y;
        logic [2:0] idx;
        logic       valid, wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic e, input logic [1:0] m,
                       input logic [2:0] s, input logic l, input logic st,
                       input logic [7:0] ey, input logic [2:0] ei,
                       input logic ev, input logic ew);
        vec_t v;
        v.name = nm; v.rst_n = r; v.en = e; v.mode = m; v.sel = s; v.load = l; v.step = st;
        v.y = ey; v.idx = ei; v.valid = ev; v.wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; step = 1'b0;
        sel3 = '0; sel2 = '0; sel4 = '0;
        @(posedge clk); #1;

        //   name         rst en mode  sel load step  y      idx v w
        add("reset",      0, 1, 2'b01, 3'd0, 0, 0, 8'h00, 3'd0, 0, 0);
        add("direct0",    1, 1, 2'b00, 3'd0, 0, 0, 8'h01, 3'd0, 1, 0);
        add("direct1",    1, 1, 2'b00, 3'd1, 0, 0, 8'h02, 3'd1, 1, 0);
        add("direct2",    1, 1, 2'b00, 3'd2, 1, 1, 8'h04, 3'd2, 1, 0);
        add("direct3",    1, 1, 2'b00, 3'd3, 0, 0, 8'h08, 3'd3, 1, 0);
        add("direct4",    1, 1, 2'b00, 3'd4, 0, 0, 8'h10, 3'd4, 1, 0);
        add("direct5",    1, 1, 2'b00, 3'd5, 0, 0, 8'h20, 3'd5, 1, 0);
        add("direct6",    1, 1, 2'b00, 3'd6, 1, 0, 8'h40, 3'd6, 1, 0);
        add("direct7",    1, 1, 2'b00, 3'd7, 0, 1, 8'h80, 3'd7, 1, 0);
        // cnt=7 > LAST: next up-advance wraps
        add("up_over",    1, 1, 2'b01, 3'd0, 0, 0, 8'h01, 3'd0, 1, 1);
        add("up1",        1, 1, 2'b01, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("up2",        1, 1, 2'b01, 3'd0, 0, 0, 8'h04, 3'd2, 1, 0);
        add("up3",        1, 1, 2'b01, 3'd0, 0, 0, 8'h08, 3'd3, 1, 0);
        add("up4",        1, 1, 2'b01, 3'd0, 0, 0, 8'h10, 3'd4, 1, 0);
        add("up5",        1, 1, 2'b01, 3'd0, 0, 0, 8'h20, 3'd5, 1, 0);
        add("up_wrap",    1, 1, 2'b01, 3'd0, 0, 0, 8'h01, 3'd0, 1, 1);
        add("up1b",       1, 1, 2'b01, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("dn_load7",   1, 1, 2'b10, 3'd7, 1, 0, 8'h20, 3'd5, 1, 0);
        add("dn4",        1, 1, 2'b10, 3'd0, 0, 0, 8'h10, 3'd4, 1, 0);
        add("dn3",        1, 1, 2'b10, 3'd0, 0, 0, 8'h08, 3'd3, 1, 0);
        add("dn2",        1, 1, 2'b10, 3'd0, 0, 0, 8'h04, 3'd2, 1, 0);
        add("dn1",        1, 1, 2'b10, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("dn0",        1, 1, 2'b10, 3'd0, 0, 0, 8'h01, 3'd0, 1, 0);
        add("dn_wrap",    1, 1, 2'b10, 3'd0, 0, 0, 8'h20, 3'd5, 1, 1);
        add("dir7_pre",   1, 1, 2'b00, 3'd7, 0, 0, 8'h80, 3'd7, 1, 0);
        add("dn_over",    1, 1, 2'b10, 3'd0, 0, 0, 8'h40, 3'd6, 1, 0);
        add("st_load0",   1, 1, 2'b11, 3'd0, 1, 0, 8'h01, 3'd0, 1, 0);
        add("st_hold1",   1, 1, 2'b11, 3'd0, 0, 0, 8'h01, 3'd0, 1, 0);
        add("st_step1",   1, 1, 2'b11, 3'd0, 0, 1, 8'h02, 3'd1, 1, 0);
        add("st_hold3",   1, 1, 2'b11, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("st_hold4",   1, 1, 2'b11, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("st_step2",   1, 1, 2'b11, 3'd0, 0, 1, 8'h04, 3'd2, 1, 0);
        add("st_step3",   1, 1, 2'b11, 3'd0, 0, 1, 8'h08, 3'd3, 1, 0);
        add("st_ldstep",  1, 1, 2'b11, 3'd4, 1, 1, 8'h10, 3'd4, 1, 0);
        add("st_step5",   1, 1, 2'b11, 3'd0, 0, 1, 8'h20, 3'd5, 1, 0);
        add("st_wrap",    1, 1, 2'b11, 3'd0, 0, 1, 8'h01, 3'd0, 1, 1);
        add("sc_up1",     1, 1, 2'b01, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);
        add("sc_up2",     1, 1, 2'b01, 3'd0, 0, 0, 8'h04, 3'd2, 1, 0);
        add("en_off",     1, 0, 2'b01, 3'd0, 0, 0, 8'h00, 3'd2, 0, 0);
        add("en_off_ld",  1, 0, 2'b01, 3'd7, 1, 1, 8'h00, 3'd2, 0, 0);
        add("en_resume",  1, 1, 2'b01, 3'd0, 0, 0, 8'h08, 3'd3, 1, 0);
        add("sc_up4",     1, 1, 2'b01, 3'd0, 0, 0, 8'h10, 3'd4, 1, 0);
        add("rst_mid",    0, 1, 2'b01, 3'd0, 0, 0, 8'h00, 3'd0, 0, 0);
        add("post_rst",   1, 1, 2'b01, 3'd0, 0, 0, 8'h02, 3'd1, 1, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode;
            sel3 = vecs[i].sel; load = vecs[i].load; step = vecs[i].step;
            tick();
            checks++;
            if (y3 !== vecs[i].y || idx3 !== vecs[i].idx ||
                valid3 !== vecs[i].valid || wrap3 !== vecs[i].wrap) begin
                errors++;
                $display("FAIL %s: got y=%h idx=%0d valid=%b wrap=%b, want y=%h idx=%0d valid=%b wrap=%b",
                         vecs[i].name, y3, idx3, valid3, wrap3,
                         vecs[i].y, vecs[i].idx, vecs[i].valid, vecs[i].wrap);
            end else begin
                $display("vec %-10s y=%h idx=%0d valid=%b wrap=%b", vecs[i].name, y3, idx3, valid3, wrap3);
            end
        end

        // Parameter sweep: reset, DIRECT over full range, then SCAN_UP from the max.
        rst_n = 1'b0; en = 1'b1; mode = 2'b00; load = 1'b0; step = 1'b0;
        tick();
        checks++;
        if (y2 !== 4'h0 || idx2 !== 2'd0 || valid2 !== 1'b0 || y4 !== 16'h0 || idx4 !== 4'd0 || valid4 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_reset: got y2=%h idx2=%0d v2=%b y4=%h idx4=%0d v4=%b, want all 0",
                     y2, idx2, valid2, y4, idx4, valid4);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  ey2;
            logic [15:0] ey4;
            sel2 = 2'(i); sel4 = 4'(i);
            ey2 = 4'b0001 << (i % 4);
            ey4 = 16'h0001 << i;
            tick();
            checks++;
            if (y2 !== ey2 || idx2 !== 2'(i) || y4 !== ey4 || idx4 !== 4'(i) ||
                !valid2 || !valid4 || !$onehot(y2) || !$onehot(y4)) begin
                errors++;
                $display("FAIL sweep_direct%0d: got y2=%h idx2=%0d y4=%h idx4=%0d, want y2=%h idx2=%0d y4=%h idx4=%0d",
                         i, y2, idx2, y4, idx4, ey2, i % 4, ey4, i);
            end else begin
                $display("direct %0d y2=%h y4=%h", i, y2, y4);
            end
        end
        // Both counters sit at their max (3 and 15): first scan step wraps.
        mode = 2'b01;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] ei2;
            logic [3:0] ei4;
            ei2 = 2'(k % 4);
            ei4 = 4'(k % 16);
            tick();
            checks++;
            if (idx2 !== ei2 || idx4 !== ei4 || wrap2 !== (ei2 == 2'd0) || wrap4 !== (ei4 == 4'd0) ||
                y2 !== (4'b0001 << ei2) || y4 !== (16'h0001 << ei4) || !$onehot(y2) || !$onehot(y4)) begin
                errors++;
                $display("FAIL sweep_scan%0d: got idx2=%0d w2=%b y2=%h idx4=%0d w4=%b y4=%h, want idx2=%0d w2=%b idx4=%0d w4=%b",
                         k, idx2, wrap2, y2, idx4, wrap4, y4, ei2, ei2 == 2'd0, ei4, ei4 == 4'd0);
            end else begin
                $display("scan %0d idx2=%0d w2=%b idx4=%0d w4=%b", k, idx2, wrap2, idx4, wrap4);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
